// File: rtl/fifo_loader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_loader_pkg
// Shared definitions for the fifo_loader block.
//   - DEFAULT_DEPTH / DEFAULT_BITS : default geometry of the attached delay fifo
//   - state_e                      : loader FSM state encoding
// -----------------------------------------------------------------------------
package fifo_loader_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_BITS  = 64;

    // Loader FSM states; encodings are fixed so waveforms stay comparable
    // with older revisions of the block.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // nothing loaded
        ST_LOAD  = 2'd1,   // some words loaded, room for more
        ST_FULL  = 2'd2,   // DEPTH words loaded, input closed
        ST_DRAIN = 2'd3    // shifting the delay fifo out
    } state_e;

endpackage : fifo_loader_pkg

// File: rtl/fifo_loader.sv
// -----------------------------------------------------------------------------
// fifo_loader
// Loads host words into an external shift delay fifo and, on request, shifts
// the whole fifo out, presenting only the words that were actually loaded.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid      : host word available on in_data
//   in_ready      : loader accepts a word this cycle (registered)
//   in_data       : host write word
//   start_drain   : single-cycle request to shift all loaded words out
//   fifo_en       : shift enable to the delay fifo (combinational)
//   fifo_d        : word shifted into the delay fifo (combinational)
//   fifo_q        : oldest entry of the delay fifo
//   out_valid     : out_data holds a loaded word (no backpressure)
//   out_data      : drained word
//   loaded        : DEPTH words held, input closed
//   busy          : drain in progress
// -----------------------------------------------------------------------------
module fifo_loader
    import fifo_loader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int BITS  = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_data,
    input  logic            start_drain,
    output logic            fifo_en,
    output logic [BITS-1:0] fifo_d,
    input  logic [BITS-1:0] fifo_q,
    output logic            out_valid,
    output logic [BITS-1:0] out_data,
    output logic            loaded,
    output logic            busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);
    localparam logic [CW:0]   DEPTH_X  = (CW + 1)'(DEPTH);

    state_e          state_q,     state_d;
    logic [CW-1:0]   count_q,     count_d;
    logic [IW-1:0]   idx_q,       idx_d;
    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [BITS-1:0] out_data_q,  out_data_d;

    logic            handshake_s;
    logic            draining_s;
    logic            keep_s;
    logic [CW:0]     pos_sum_s;

    assign handshake_s = in_valid & in_ready_q;
    assign draining_s  = (state_q == ST_DRAIN);

    // The fifo holds DEPTH-count stale/zero entries ahead of the loaded words,
    // so drain shift k carries a loaded word exactly when k + count >= DEPTH.
    assign pos_sum_s = {1'b0, count_q} + (CW + 1)'(idx_q);
    assign keep_s    = (pos_sum_s >= DEPTH_X);

    // Next-state, count and drain-index computation.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake_s) begin
                    state_d = ST_LOAD;
                    count_d = count_q + CW'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (handshake_s) begin
                    count_d = count_q + CW'(1);
                end else begin
                    count_d = count_q;
                end
                // A drain request wins over filling up: the word taken in the
                // same cycle is already counted and is drained with the rest.
                if (start_drain) begin
                    state_d = ST_DRAIN;
                    idx_d   = {IW{1'b0}};
                end else if (handshake_s && (count_q == CNT_LAST)) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FULL: begin
                if (start_drain) begin
                    state_d = ST_DRAIN;
                    idx_d   = {IW{1'b0}};
                end else begin
                    state_d = ST_FULL;
                end
            end
            ST_DRAIN: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_IDLE;
                    count_d = {CW{1'b0}};
                    idx_d   = {IW{1'b0}};
                end else begin
                    state_d = ST_DRAIN;
                    idx_d   = idx_q + IW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = {CW{1'b0}};
                idx_d   = {IW{1'b0}};
            end
        endcase
    end

    // Ready and output-capture next values. in_ready is a flop so that it
    // stays low while rst is held and rises on the first edge after release.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        out_valid_d = draining_s & keep_s;
        if (draining_s) begin
            out_data_d = fifo_q;
        end else begin
            out_data_d = out_data_q;
        end
    end

    // Shift interface to the delay fifo: host word on a handshake, zero
    // padding during drain.
    always_comb begin
        fifo_en = handshake_s | draining_s;
        if (handshake_s) begin
            fifo_d = in_data;
        end else begin
            fifo_d = {BITS{1'b0}};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= {CW{1'b0}};
            idx_q       <= {IW{1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {BITS{1'b0}};
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign loaded    = (state_q == ST_FULL);
    assign busy      = draining_s;

endmodule : fifo_loader

// File: tb/tb_fifo_loader.sv
// -----------------------------------------------------------------------------
// tb_fifo_loader
// Self-checking bench for fifo_loader (DEPTH=8, BITS=64) wired to a simple
// shift delay fifo modelled here. Cycle vectors hold the inputs for one clock
// and the outputs expected in that clock; multi-cycle corner cases (reset in
// the middle of a drain) are written out by hand.
// -----------------------------------------------------------------------------
module tb_fifo_loader;

    localparam int DEPTH = 8;
    localparam int BITS  = 64;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] in_data;
    logic            start_drain;
    logic            fifo_en;
    logic [BITS-1:0] fifo_d;
    logic [BITS-1:0] fifo_q;
    logic            out_valid;
    logic [BITS-1:0] out_data;
    logic            loaded;
    logic            busy;

    int n_cmp;
    int n_bad;

    fifo_loader #(.DEPTH(DEPTH), .BITS(BITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .start_drain (start_drain),
        .fifo_en     (fifo_en),
        .fifo_d      (fifo_d),
        .fifo_q      (fifo_q),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .loaded      (loaded),
        .busy        (busy)
    );

    // Delay fifo: DEPTH-entry shift register, oldest entry at the far end,
    // cleared together with the loader through its active-low reset.
    logic [BITS-1:0] dly_q [DEPTH];
    logic            dly_rst_n;
    assign dly_rst_n = ~rst;
    assign fifo_q    = dly_q[DEPTH-1];

    always_ff @(posedge clk or negedge dly_rst_n) begin
        if (!dly_rst_n) begin
            for (int i = 0; i < DEPTH; i++) dly_q[i] <= '0;
        end else if (fifo_en) begin
            dly_q[0] <= fifo_d;
            for (int i = 1; i < DEPTH; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [63:0] d;
        logic        sd;
        logic        en;
        logic [63:0] fd;
        logic        rdy;
        logic        ld;
        logic        bsy;
        logic        ov;
        logic [63:0] od;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic iv, input logic [63:0] d, input logic sd,
                                input logic en, input logic [63:0] fd,
                                input logic rdy, input logic ld, input logic bsy,
                                input logic ov, input logic [63:0] od);
        vec_t v;
        v.iv = iv; v.d = d; v.sd = sd; v.en = en; v.fd = fd;
        v.rdy = rdy; v.ld = ld; v.bsy = bsy; v.ov = ov; v.od = od;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Apply one vector: drive after the rising edge, check on the falling edge.
    task automatic run_vec(input vec_t v, input int idx);
        in_valid    = v.iv;
        in_data     = v.d;
        start_drain = v.sd;
        @(negedge clk);
        chk($sformatf("v%0d fifo_en", idx), 64'(fifo_en), 64'(v.en));
        if (v.en) chk($sformatf("v%0d fifo_d", idx), fifo_d, v.fd);
        chk($sformatf("v%0d in_ready", idx), 64'(in_ready), 64'(v.rdy));
        chk($sformatf("v%0d loaded", idx), 64'(loaded), 64'(v.ld));
        chk($sformatf("v%0d busy", idx), 64'(busy), 64'(v.bsy));
        chk($sformatf("v%0d out_valid", idx), 64'(out_valid), 64'(v.ov));
        if (v.ov) chk($sformatf("v%0d out_data", idx), out_data, v.od);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " out_data"},  out_data,       64'd0);
        chk({tag, " fifo_en"},   64'(fifo_en),   64'd0);
        chk({tag, " fifo_d"},    fifo_d,         64'd0);
        chk({tag, " loaded"},    64'(loaded),    64'd0);
        chk({tag, " busy"},      64'(busy),      64'd0);
        chk({tag, " in_ready"},  64'(in_ready),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seen;
        int          cyc;
        logic [63:0] got[$];

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 64'd0;
        start_drain = 1'b0;

        // ---- Reset pulse: all outputs low, in_ready one cycle after release
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_reset in_ready", 64'(in_ready), 64'd1);
        chk("post_reset busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // ---- Full load 0x11..0x88, extra word refused while full, drain
        for (int i = 1; i <= 8; i++)
            add(1'b1, 64'h11 * 64'(i), 1'b0, 1'b1, 64'h11 * 64'(i), 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        add(1'b1, 64'h99, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
        add(1'b1, 64'h99, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
        add(1'b0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
        for (int k = 1; k < 8; k++)
            add(1'b0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h11 * 64'(k));
        add(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h88);
        add(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);

        // ---- start_drain with nothing loaded is ignored
        add(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        add(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);

        // ---- Partial load 0xA,0xB,0xC (with an idle gap); only 3 words out,
        //      and a repeated start_drain mid-drain is ignored
        add(1'b1, 64'hA, 1'b0, 1'b1, 64'hA, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        add(1'b0, 64'hEE, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        add(1'b1, 64'hB, 1'b0, 1'b1, 64'hB, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        add(1'b1, 64'hC, 1'b0, 1'b1, 64'hC, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        add(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        for (int k = 0; k < 8; k++)
            add(1'b0, 64'd0, (k == 3) ? 1'b1 : 1'b0, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1,
                (k >= 6) ? 1'b1 : 1'b0, (k == 6) ? 64'hA : 64'hB);
        add(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, 64'hC);
        add(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);

        // ---- Four words, fifth handshake coincident with start_drain
        for (int i = 1; i <= 4; i++)
            add(1'b1, 64'h100 + 64'(i), 1'b0, 1'b1, 64'h100 + 64'(i), 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        add(1'b1, 64'h105, 1'b1, 1'b1, 64'h105, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        for (int k = 0; k < 8; k++)
            add(1'b0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1,
                (k >= 4) ? 1'b1 : 1'b0, 64'h101 + 64'(k) - 64'd4);
        add(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h105);
        add(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // ---- Reset in the middle of a drain after three outputs
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h200 + 64'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start_drain = 1'b1;
        @(negedge clk);
        chk("mid_rst loaded_before_drain", 64'(loaded), 64'd1);
        @(posedge clk); #1;
        start_drain = 1'b0;
        seen = 0;
        cyc = 0;
        while (seen < 3 && cyc < 20) begin
            @(negedge clk);
            if (out_valid) seen++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("mid_rst outputs_before_reset", 64'(seen), 64'd3);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_rst in_ready", 64'(in_ready), 64'd1);
        chk("after_rst out_valid", 64'(out_valid), 64'd0);
        chk("after_rst busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Reload: count must restart at zero, so loaded rises only after the 8th word
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h300 + 64'(i);
            @(negedge clk);
            chk($sformatf("reload%0d in_ready", i), 64'(in_ready), 64'd1);
            chk($sformatf("reload%0d out_valid", i), 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start_drain = 1'b1;
        @(negedge clk);
        chk("reload loaded", 64'(loaded), 64'd1);
        @(posedge clk); #1;
        start_drain = 1'b0;
        cyc = 0;
        while (got.size() < 8 && cyc < 30) begin
            @(negedge clk);
            if (out_valid) got.push_back(out_data);
            @(posedge clk); #1;
            cyc++;
        end
        chk("reload word_count", 64'(got.size()), 64'd8);
        for (int j = 0; j < got.size(); j++)
            chk($sformatf("reload word%0d", j), got[j], 64'h301 + 64'(j));
        @(negedge clk);
        chk("reload final in_ready", 64'(in_ready), 64'd1);
        chk("reload final out_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fifo_loader
